// File: rtl/neo_pkg.sv
// Types and constants shared by the NeoPixel pattern sequencer and the strand controller.
package neo_pkg;

  localparam int CLOCK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    COLOR_RED   = 2'b00,
    COLOR_BLUE  = 2'b01,
    COLOR_GREEN = 2'b10
  } color_index_t;

  typedef enum logic [1:0] {
    SOLID = 2'b00,
    CHASE = 2'b01,
    BLINK = 2'b10,
    OFF   = 2'b11
  } pattern_mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOAD,
    S_SEND,
    S_HOLD
  } seq_state_t;

  function automatic logic [7:0] channel_of(color_index_t ch, logic [7:0] r, logic [7:0] g,
                                            logic [7:0] b);
    case (ch)
      COLOR_RED:  channel_of = r;
      COLOR_BLUE: channel_of = b;
      default:    channel_of = g;
    endcase
  endfunction

endpackage

// File: rtl/neo_pattern_sequencer_if.sv
// Load/send bus between the pattern sequencer (master) and the strand controller (slave).
interface neo_pattern_sequencer_if;
  import neo_pkg::*;

  logic [7:0]   color_level;
  color_index_t color_index;
  logic [2:0]   pixel_index;
  logic         load_color;
  logic         send_it;
  logic         ready_to_load;
  logic         ready_to_send;

  modport master (
    output color_level, color_index, pixel_index, load_color, send_it,
    input  ready_to_load, ready_to_send
  );

  modport slave (
    input  color_level, color_index, pixel_index, load_color, send_it,
    output ready_to_load, ready_to_send
  );

endinterface

// File: rtl/neo_counter.sv
// Generic up-counter with synchronous clear that saturates at LIMIT.
module neo_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (step && (count != LIMIT)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/neo_frame_timer.sv
// Frame-period timer: counts cycles since the frame start and flags the final cycle.
module neo_frame_timer #(
  parameter int FRAME_CYCLES = 2500000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int               WIDTH = $clog2(FRAME_CYCLES);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(FRAME_CYCLES - 1);

  logic [WIDTH-1:0] count;

  neo_counter #(
    .WIDTH (WIDTH),
    .LIMIT (LAST)
  ) u_counter (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .step  (run),
    .count (count)
  );

  assign expired = (count == LAST);

endmodule

// File: rtl/neo_pattern_sequencer.sv
// Generates animation frames: latches mode/colour, writes every colour register, fires send_it,
// then waits out the frame period.
module neo_pattern_sequencer
  import neo_pkg::*;
#(
  parameter int NUM_PIXELS   = 5,
  parameter int FRAME_CYCLES = 2500000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [7:0]              base_r,
  input  logic [7:0]              base_g,
  input  logic [7:0]              base_b,
  neo_pattern_sequencer_if.master bus,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    frame_overrun
);

  seq_state_t    state, next_state;
  pattern_mode_t frame_mode, src_mode;
  logic [7:0]    frame_r, frame_g, frame_b, src_r, src_g, src_b;
  logic [2:0]    pixel, next_pixel, pos;
  color_index_t  channel, next_channel;
  logic [7:0]    level, next_level;
  logic          phase, overrun;
  logic          load_color, send_it, last_item, item_update;
  logic          timer_clear, timer_run, timer_expired;

  function automatic logic pixel_lit(pattern_mode_t m, logic [2:0] p, logic [2:0] cur_pos,
                                     logic ph);
    case (m)
      SOLID:   pixel_lit = 1'b1;
      CHASE:   pixel_lit = (p == cur_pos);
      BLINK:   pixel_lit = ~ph;
      default: pixel_lit = 1'b0;
    endcase
  endfunction

  assign last_item = (pixel == 3'(NUM_PIXELS - 1)) && (channel == COLOR_GREEN);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_color = 1'b0;
    send_it    = 1'b0;
    case (state)
      S_IDLE:  if (enable) next_state = S_LATCH;
      S_LATCH: next_state = S_LOAD;
      S_LOAD: begin
        load_color = bus.ready_to_load;
        if (load_color && last_item) next_state = S_SEND;
      end
      S_SEND: begin
        send_it = bus.ready_to_send;
        if (send_it) next_state = S_HOLD;
      end
      S_HOLD:  if (timer_expired) next_state = enable ? S_LATCH : S_IDLE;
      default: next_state = S_IDLE;
    endcase
    // Clearing on entry to LATCH makes LATCH count 0, so LATCH-to-LATCH is exactly FRAME_CYCLES.
    timer_clear = (next_state == S_LATCH);
    timer_run   = (state != S_IDLE);
  end

  // LATCH primes item 0 straight from the live inputs; later items use the latched frame values.
  always_comb begin
    src_mode     = frame_mode;
    src_r        = frame_r;
    src_g        = frame_g;
    src_b        = frame_b;
    next_pixel   = pixel;
    next_channel = channel;
    item_update  = 1'b0;
    if (state == S_LATCH) begin
      src_mode     = pattern_mode_t'(mode);
      src_r        = base_r;
      src_g        = base_g;
      src_b        = base_b;
      next_pixel   = 3'd0;
      next_channel = COLOR_RED;
      item_update  = 1'b1;
    end else if (load_color && !last_item) begin
      item_update = 1'b1;
      case (channel)
        COLOR_RED:  next_channel = COLOR_BLUE;
        COLOR_BLUE: next_channel = COLOR_GREEN;
        default: begin
          next_channel = COLOR_RED;
          next_pixel   = pixel + 3'd1;
        end
      endcase
    end
    next_level = pixel_lit(src_mode, next_pixel, pos, phase)
               ? channel_of(next_channel, src_r, src_g, src_b) : 8'h00;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_mode <= SOLID;
      frame_r    <= 8'h00;
      frame_g    <= 8'h00;
      frame_b    <= 8'h00;
      pixel      <= 3'd0;
      channel    <= COLOR_RED;
      level      <= 8'h00;
    end else begin
      if (state == S_LATCH) begin
        frame_mode <= pattern_mode_t'(mode);
        frame_r    <= base_r;
        frame_g    <= base_g;
        frame_b    <= base_b;
      end
      if (item_update) begin
        pixel   <= next_pixel;
        channel <= next_channel;
        level   <= next_level;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pos   <= 3'd0;
      phase <= 1'b0;
    end else if (send_it) begin
      case (frame_mode)
        CHASE:   pos <= (pos == 3'(NUM_PIXELS - 1)) ? 3'd0 : pos + 3'd1;
        BLINK:   phase <= ~phase;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (timer_expired &&
                 ((state == S_LATCH) || (state == S_LOAD) || (state == S_SEND))) begin
      overrun <= 1'b1;
    end
  end

  neo_frame_timer #(
    .FRAME_CYCLES (FRAME_CYCLES)
  ) u_frame_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .run     (timer_run),
    .expired (timer_expired)
  );

  assign bus.color_level = level;
  assign bus.color_index = channel;
  assign bus.pixel_index = pixel;
  assign bus.load_color  = load_color;
  assign bus.send_it     = send_it;
  assign busy            = (state != S_IDLE);
  assign frame_done      = send_it;
  assign frame_overrun   = overrun;

endmodule

// File: tb/tb_neo_pattern_sequencer.sv
// Self-checking bench for neo_pattern_sequencer: frame vectors from a table plus
// hand-written stall, overrun, enable-drop and mid-frame reset sequences.
module tb_neo_pattern_sequencer;
  import neo_pkg::*;

  localparam int NUM_PIXELS   = 5;
  localparam int FRAME_CYCLES = 200;
  localparam int ITEMS        = NUM_PIXELS * 3;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [4:0] lit;
  } frame_vec_t;

  typedef struct packed {
    logic [2:0] pix;
    logic [1:0] idx;
    logic [7:0] lvl;
  } write_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] base_r = 8'h00;
  logic [7:0] base_g = 8'h00;
  logic [7:0] base_b = 8'h00;
  logic       busy, frame_done, frame_overrun;

  int         errors = 0;
  int         checks = 0;
  int         cycle_count = 0;
  int         done_count = 0;
  int         send_count = 0;
  bit         both_seen = 1'b0;
  write_t     writes[$];
  int         done_cycles[$];
  frame_vec_t vecs[12];
  frame_vec_t stall_vec, chase_vec;
  bit         stall_bad;

  neo_pattern_sequencer_if bus();

  neo_pattern_sequencer #(
    .NUM_PIXELS   (NUM_PIXELS),
    .FRAME_CYCLES (FRAME_CYCLES)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .mode          (mode),
    .base_r        (base_r),
    .base_g        (base_g),
    .base_b        (base_b),
    .bus           (bus),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_overrun (frame_overrun)
  );

  always #5 clock = ~clock;

  // Record accepted writes and strobes on the falling edge, away from the active edge.
  always @(negedge clock) begin
    cycle_count++;
    if (bus.load_color) writes.push_back({bus.pixel_index, bus.color_index, bus.color_level});
    if (bus.send_it) send_count++;
    if (frame_done) begin
      done_count++;
      done_cycles.push_back(cycle_count);
    end
    if (bus.load_color && bus.send_it) both_seen = 1'b1;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input frame_vec_t v);
    mode   = v.mode;
    base_r = v.r;
    base_g = v.g;
    base_b = v.b;
  endtask

  task automatic check_frame(input string name, input frame_vec_t v);
    check_output({name, " write count"}, writes.size(), ITEMS);
    for (int k = 0; k < ITEMS && k < writes.size(); k++) begin
      int         p;
      int         c;
      logic [2:0] pix;
      logic [1:0] idx;
      logic [7:0] lvl;
      p   = k / 3;
      c   = k % 3;
      pix = 3'(p);
      case (c)
        0:       begin idx = 2'b00; lvl = v.r; end
        1:       begin idx = 2'b01; lvl = v.b; end
        default: begin idx = 2'b10; lvl = v.g; end
      endcase
      if (!v.lit[p]) lvl = 8'h00;
      check_output($sformatf("%s write %0d", name, k), 32'(writes[k]), 32'({pix, idx, lvl}));
    end
  endtask

  task automatic wait_frame_done(input string name, input int limit);
    int start;
    int n;
    start = done_count;
    n = 0;
    while (done_count == start && n < limit) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_output({name, " frame_done seen"}, done_count - start, 1);
  endtask

  task automatic wait_writes(input string name, input int count, input int limit);
    int n;
    n = 0;
    while (writes.size() < count && n < limit) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_output({name, " writes reached"}, writes.size(), count);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_output({name, " busy low"}, busy, 0);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 8'h10, 8'h20, 8'h30, 5'b11111};
    vecs[1]  = '{2'b01, 8'hFF, 8'h00, 8'h00, 5'b00001};
    vecs[2]  = '{2'b01, 8'hFF, 8'h00, 8'h00, 5'b00010};
    vecs[3]  = '{2'b01, 8'hFF, 8'h00, 8'h00, 5'b00100};
    vecs[4]  = '{2'b01, 8'hFF, 8'h00, 8'h00, 5'b01000};
    vecs[5]  = '{2'b01, 8'hFF, 8'h00, 8'h00, 5'b10000};
    vecs[6]  = '{2'b01, 8'hFF, 8'h00, 8'h00, 5'b00001};
    vecs[7]  = '{2'b01, 8'hFF, 8'h00, 8'h00, 5'b00010};
    vecs[8]  = '{2'b10, 8'h0A, 8'h0B, 8'h0C, 5'b11111};
    vecs[9]  = '{2'b10, 8'h0A, 8'h0B, 8'h0C, 5'b00000};
    vecs[10] = '{2'b10, 8'h0A, 8'h0B, 8'h0C, 5'b11111};
    vecs[11] = '{2'b10, 8'h0A, 8'h0B, 8'h0C, 5'b00000};
    stall_vec = '{2'b00, 8'h01, 8'h02, 8'h03, 5'b11111};
    chase_vec = '{2'b01, 8'h00, 8'h40, 8'h00, 5'b00001};

    bus.ready_to_load = 1'b1;
    bus.ready_to_send = 1'b1;

    repeat (3) @(posedge clock);
    #1;
    check_output("reset busy", busy, 0);
    check_output("reset load_color", bus.load_color, 0);
    check_output("reset send_it", bus.send_it, 0);
    check_output("reset frame_done", frame_done, 0);
    check_output("reset color_level", bus.color_level, 0);
    check_output("reset color_index", bus.color_index, 0);
    check_output("reset pixel_index", bus.pixel_index, 0);
    check_output("reset frame_overrun", frame_overrun, 0);
    reset = 1'b0;

    // Back-to-back frames: solid, seven chase, four blink.
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i]);
      writes.delete();
      if (i == 0) enable = 1'b1;
      wait_frame_done($sformatf("vec %0d", i), 600);
      check_frame($sformatf("vec %0d", i), vecs[i]);
    end
    check_output("frame_done total", done_count, 12);
    for (int i = 1; i < 12 && i < done_cycles.size(); i++) begin
      check_output($sformatf("frame period %0d", i), done_cycles[i] - done_cycles[i-1],
                   FRAME_CYCLES);
    end
    enable = 1'b0;
    wait_idle("table end", 400);
    check_output("table overrun", frame_overrun, 0);

    $display("[TB] ready_to_load stall of 50 cycles");
    apply_stimulus(stall_vec);
    writes.delete();
    enable = 1'b1;
    wait_writes("stall", 6, 400);
    bus.ready_to_load = 1'b0;
    stall_bad = 1'b0;
    repeat (50) begin
      @(posedge clock);
      #1;
      if (bus.load_color || bus.pixel_index != 3'd2 || bus.color_index != COLOR_RED ||
          bus.color_level != 8'h01) stall_bad = 1'b1;
    end
    check_output("stall outputs frozen", stall_bad, 0);
    check_output("stall write count", writes.size(), 6);
    bus.ready_to_load = 1'b1;
    wait_frame_done("stall", 300);
    check_frame("stall frame", stall_vec);
    check_output("stall overrun", frame_overrun, 0);

    $display("[TB] ready_to_load stall of 300 cycles, then enable dropped");
    writes.delete();
    wait_writes("overrun", 2, 400);
    bus.ready_to_load = 1'b0;
    repeat (300) @(posedge clock);
    #1;
    check_output("overrun set", frame_overrun, 1);
    bus.ready_to_load = 1'b1;
    enable = 1'b0;
    wait_frame_done("overrun", 100);
    check_frame("overrun frame", stall_vec);
    wait_idle("enable drop", 100);
    check_output("overrun sticky", frame_overrun, 1);
    repeat (20) @(posedge clock);
    #1;
    check_output("idle no writes", writes.size(), ITEMS);

    $display("[TB] reset mid-LOAD");
    apply_stimulus(chase_vec);
    writes.delete();
    enable = 1'b1;
    wait_writes("mid reset", 4, 50);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_output("mid reset busy", busy, 0);
    check_output("mid reset load_color", bus.load_color, 0);
    check_output("mid reset send_it", bus.send_it, 0);
    check_output("mid reset color_level", bus.color_level, 0);
    check_output("mid reset color_index", bus.color_index, 0);
    check_output("mid reset pixel_index", bus.pixel_index, 0);
    check_output("mid reset frame_overrun", frame_overrun, 0);
    reset = 1'b0;
    writes.delete();
    wait_frame_done("post reset", 400);
    check_frame("post reset chase", chase_vec);
    enable = 1'b0;

    check_output("load and send exclusive", both_seen, 0);
    check_output("send count", send_count, done_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
